rom_port_arbiter: RTL and testbench

Two-requester arbiter and response sequencer for the core's single-read-port instruction ROM (128 words × 32 bits, byte-addressed, combinational read). It sits between the ROM and the core datapath and shares the ROM between the instruction-fetch port (port 0) and the data-load port (port 1), used for constant reads from ROM. Each accepted request is answered one cycle later from a per-port response register with backpressure. A saturating contention counter supports performance debug.

---
 rtl/rom_arb_pkg.sv | 13 +
 rtl/rom_resp_slot.sv | 26 ++
 rtl/rom_port_arbiter.sv | 101 ++++++++++
 tb/tb_rom_port_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared port indices and the response word type for the ROM port arbiter.
package rom_arb_pkg;

  localparam int NPORTS  = 2;
  localparam int PORT_IF = 0;
  localparam int PORT_LD = 1;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rom_resp_t;

endpackage

// File: rtl/rom_resp_slot.sv
// Single-entry response register with valid/ready handshake; a load wins over a take.
module rom_resp_slot
  import rom_arb_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      load,
  input  rom_resp_t load_resp,
  input  logic      take,
  output logic      valid,
  output rom_resp_t resp
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      resp  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      resp  <= load_resp;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares a combinational single-port ROM between instruction fetch (port 0) and
// data load (port 1); round-robin on contention, one-cycle registered responses.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int AW    = 12,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid_0,
  input  logic [AW-1:0] req_addr_0,
  output logic          req_ready_0,
  output logic          resp_valid_0,
  output logic [31:0]   resp_data_0,
  output logic          resp_err_0,
  input  logic          resp_ready_0,
  input  logic          req_valid_1,
  input  logic [AW-1:0] req_addr_1,
  output logic          req_ready_1,
  output logic          resp_valid_1,
  output logic [31:0]   resp_data_1,
  output logic          resp_err_1,
  input  logic          resp_ready_1,
  output logic [AW-1:0] rom_addr,
  input  logic [31:0]   rom_inst,
  output logic [CW-1:0] contention_cnt
);

  localparam logic [AW-2:0] WORD_LIM = (AW-1)'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  function automatic logic addr_err(input logic [AW-1:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a[AW-1:2]} >= WORD_LIM);
  endfunction

  function automatic rom_resp_t make_resp(input logic [AW-1:0] a, input logic [31:0] inst);
    rom_resp_t r;
    r.err  = addr_err(a);
    r.data = r.err ? 32'h0 : inst;
    return r;
  endfunction

  logic      rr_ptr;
  logic      elig_0, elig_1;
  logic      grant_0, grant_1;
  rom_resp_t grant_resp_p0;
  rom_resp_t slot_resp_0, slot_resp_1;

  assign elig_0  = req_valid_0 && (!resp_valid_0 || resp_ready_0);
  assign elig_1  = req_valid_1 && (!resp_valid_1 || resp_ready_1);
  assign grant_0 = elig_0 && (!elig_1 || (rr_ptr == 1'(PORT_IF)));
  assign grant_1 = elig_1 && (!elig_0 || (rr_ptr == 1'(PORT_LD)));

  assign req_ready_0   = grant_0;
  assign req_ready_1   = grant_1;
  assign rom_addr      = grant_1 ? req_addr_1 : req_addr_0;
  assign grant_resp_p0 = make_resp(rom_addr, rom_inst);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr         <= 1'(PORT_IF);
      contention_cnt <= '0;
    end else begin
      if (grant_0)
        rr_ptr <= 1'(PORT_LD);
      else if (grant_1)
        rr_ptr <= 1'(PORT_IF);
      if (elig_0 && elig_1 && (contention_cnt != CNT_MAX))
        contention_cnt <= contention_cnt + 1'b1;
    end
  end

  // Stage p0 -> p1: granted ROM word is captured in the requester's response slot
  rom_resp_slot u_slot_0 (
    .clk       (clk),
    .reset     (reset),
    .load      (grant_0),
    .load_resp (grant_resp_p0),
    .take      (resp_ready_0),
    .valid     (resp_valid_0),
    .resp      (slot_resp_0)
  );

  rom_resp_slot u_slot_1 (
    .clk       (clk),
    .reset     (reset),
    .load      (grant_1),
    .load_resp (grant_resp_p0),
    .take      (resp_ready_1),
    .valid     (resp_valid_1),
    .resp      (slot_resp_1)
  );

  assign resp_data_0 = slot_resp_0.data;
  assign resp_err_0  = slot_resp_0.err;
  assign resp_data_1 = slot_resp_1.data;
  assign resp_err_1  = slot_resp_1.err;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: stimulus process plus a negedge scoreboard monitor.
module tb_rom_port_arbiter;

  localparam int AW = 12;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid_0, req_valid_1;
  logic [AW-1:0] req_addr_0, req_addr_1;
  logic          req_ready_0, req_ready_1;
  logic          resp_valid_0, resp_valid_1;
  logic [31:0]   resp_data_0, resp_data_1;
  logic          resp_err_0, resp_err_1;
  logic          resp_ready_0, resp_ready_1;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_inst;
  logic [CW-1:0] contention_cnt;

  logic [31:0] rom [128];

  int n_vec = 0;
  int n_bad = 0;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic        mv0, mv1, mrr;
  logic [CW-1:0] mcnt;

  always #5 clk = ~clk;

  rom_port_arbiter #(.DEPTH(128), .AW(AW), .CW(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid_0    (req_valid_0),
    .req_addr_0     (req_addr_0),
    .req_ready_0    (req_ready_0),
    .resp_valid_0   (resp_valid_0),
    .resp_data_0    (resp_data_0),
    .resp_err_0     (resp_err_0),
    .resp_ready_0   (resp_ready_0),
    .req_valid_1    (req_valid_1),
    .req_addr_1     (req_addr_1),
    .req_ready_1    (req_ready_1),
    .resp_valid_1   (resp_valid_1),
    .resp_data_1    (resp_data_1),
    .resp_err_1     (resp_err_1),
    .resp_ready_1   (resp_ready_1),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .contention_cnt (contention_cnt)
  );

  // Out-of-range reads return a poison word so a missing zeroing shows up.
  always_comb begin
    rom_inst = 32'hDEADBEEF;
    if (rom_addr[11:2] < 10'd128) rom_inst = rom[rom_addr[8:2]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model_resp(input logic [AW-1:0] a);
    int unsigned ai;
    ai = 32'(a);
    if ((ai % 4) != 0 || (ai / 4) >= 128) return {1'b1, 32'h0};
    return {1'b0, rom[ai / 4]};
  endfunction

  // Scoreboard monitor: predicts grants, pushes expected words, pops on handshake.
  always @(negedge clk) begin
    logic e0, e1, g0, g1;
    logic [32:0] exp;
    if (reset) begin
      mv0 = 1'b0; mv1 = 1'b0; mrr = 1'b0; mcnt = '0;
      q0.delete(); q1.delete();
    end else begin
      e0 = req_valid_0 && (!mv0 || resp_ready_0);
      e1 = req_valid_1 && (!mv1 || resp_ready_1);
      g0 = e0 && (!e1 || !mrr);
      g1 = e1 && (!e0 || mrr);
      check("mon_req_ready_0", 64'(req_ready_0), 64'(g0));
      check("mon_req_ready_1", 64'(req_ready_1), 64'(g1));
      check("mon_resp_valid_0", 64'(resp_valid_0), 64'(mv0));
      check("mon_resp_valid_1", 64'(resp_valid_1), 64'(mv1));
      check("mon_contention_cnt", 64'(contention_cnt), 64'(mcnt));
      if (resp_valid_0 && resp_ready_0) begin
        if (q0.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL resp_0_unexpected: got %0h with no pending request", {resp_err_0, resp_data_0});
        end else begin
          exp = q0.pop_front();
          check("resp_0", 64'({resp_err_0, resp_data_0}), 64'(exp));
        end
      end
      if (resp_valid_1 && resp_ready_1) begin
        if (q1.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL resp_1_unexpected: got %0h with no pending request", {resp_err_1, resp_data_1});
        end else begin
          exp = q1.pop_front();
          check("resp_1", 64'({resp_err_1, resp_data_1}), 64'(exp));
        end
      end
      if (g0) q0.push_back(model_resp(req_addr_0));
      if (g1) q1.push_back(model_resp(req_addr_1));
      mv0 = g0 ? 1'b1 : (resp_ready_0 ? 1'b0 : mv0);
      mv1 = g1 ? 1'b1 : (resp_ready_1 ? 1'b0 : mv1);
      if (g0) mrr = 1'b1;
      else if (g1) mrr = 1'b0;
      if (e0 && e1 && mcnt != '1) mcnt = mcnt + 1'b1;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = {8'hA5, 8'(i), 16'h0F0F};
    rom[0] = 32'h1FC00113;
    reset = 1'b1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    req_addr_0 = '0; req_addr_1 = '0;
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_resp_valid_0", 64'(resp_valid_0), 64'd0);
    check("rst_resp_valid_1", 64'(resp_valid_1), 64'd0);
    check("rst_resp_data_0", 64'(resp_data_0), 64'd0);
    check("rst_resp_err_1", 64'(resp_err_1), 64'd0);
    check("rst_cnt", 64'(contention_cnt), 64'd0);
    check("rst_req_ready_0", 64'(req_ready_0), 64'd0);
    next_cycle();
    reset = 1'b0;

    // Single fetch from word 0
    req_valid_0 = 1'b1; req_addr_0 = 12'h000;
    @(negedge clk);
    check("fetch_req_ready_0", 64'(req_ready_0), 64'd1);
    next_cycle();
    req_valid_0 = 1'b0;
    @(negedge clk);
    check("fetch_resp_valid", 64'(resp_valid_0), 64'd1);
    check("fetch_resp_data", 64'(resp_data_0), 64'h1FC00113);
    check("fetch_resp_err", 64'(resp_err_0), 64'd0);

    // Full contention; rr_ptr points at port 1 after the fetch grant
    next_cycle();
    req_valid_0 = 1'b1; req_addr_0 = 12'h004;
    req_valid_1 = 1'b1; req_addr_1 = 12'h008;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("cont_grant_1", 64'(req_ready_1), 64'(i % 2 == 0));
      check("cont_grant_0", 64'(req_ready_0), 64'(i % 2 == 1));
      check("cont_cnt", 64'(contention_cnt), 64'(i));
      next_cycle();
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    next_cycle();

    // Backpressure on port 1 while port 0 keeps being served
    req_valid_0 = 1'b1; req_addr_0 = 12'h010;
    req_valid_1 = 1'b1; req_addr_1 = 12'h00C;
    resp_ready_1 = 1'b0;
    @(negedge clk);
    check("bp_first_grant_1", 64'(req_ready_1), 64'd1);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_req_ready_1", 64'(req_ready_1), 64'd0);
      check("bp_req_ready_0", 64'(req_ready_0), 64'd1);
      check("bp_resp_data_1", 64'(resp_data_1), 64'hA5030F0F);
      next_cycle();
    end
    resp_ready_1 = 1'b1;
    @(negedge clk);
    check("bp_release_grant_1", 64'(req_ready_1), 64'd1);
    next_cycle();
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    next_cycle();

    // Error cases: misaligned, past the end, last word
    req_valid_0 = 1'b1; req_addr_0 = 12'h002;
    next_cycle();
    req_addr_0 = 12'h200;
    @(negedge clk);
    check("err_misaligned_err", 64'(resp_err_0), 64'd1);
    check("err_misaligned_data", 64'(resp_data_0), 64'd0);
    next_cycle();
    req_addr_0 = 12'h1FC;
    @(negedge clk);
    check("err_range_err", 64'(resp_err_0), 64'd1);
    check("err_range_data", 64'(resp_data_0), 64'd0);
    next_cycle();
    req_valid_0 = 1'b0;
    @(negedge clk);
    check("last_word_err", 64'(resp_err_0), 64'd0);
    check("last_word_data", 64'(resp_data_0), 64'hA57F0F0F);

    // Asynchronous reset while a response is held
    next_cycle();
    req_valid_0 = 1'b1; req_addr_0 = 12'h014; resp_ready_0 = 1'b0;
    next_cycle();
    req_valid_0 = 1'b0;
    @(negedge clk);
    check("pre_reset_valid_0", 64'(resp_valid_0), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid_0", 64'(resp_valid_0), 64'd0);
    check("async_rst_data_0", 64'(resp_data_0), 64'd0);
    check("async_rst_cnt", 64'(contention_cnt), 64'd0);
    next_cycle();
    @(negedge clk);
    next_cycle();
    reset = 1'b0; resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    req_valid_0 = 1'b1; req_addr_0 = 12'h018;
    req_valid_1 = 1'b1; req_addr_1 = 12'h01C;
    @(negedge clk);
    check("post_rst_grant_0", 64'(req_ready_0), 64'd1);
    check("post_rst_grant_1", 64'(req_ready_1), 64'd0);

    // Saturation of the 4-bit contention counter
    for (int i = 0; i < 20; i++) next_cycle();
    @(negedge clk);
    check("sat_cnt", 64'(contention_cnt), 64'd15);
    next_cycle();
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
